// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data SRAM: the CPU MEM stage has priority,
// and a starvation counter forces a grant to the external host after MAX_WAIT denied cycles.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  // Pipeline MEM-stage port
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // External host port
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  // SRAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        ext_wait_cnt
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [0:0] {StNorm, StForce} state_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnExt} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  // Grant decision
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (enable) begin
      if (state_q == StForce) begin
        if (ext_req) begin
          ext_gnt = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt = 1'b1;
        end
      end else begin
        if (cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (ext_req) begin
          ext_gnt = 1'b1;
        end
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // SRAM request mux; idle cycles drive zeros so the bus is quiet
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    unique case ({cpu_gnt, ext_gnt})
      2'b10: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = cpu_wen;
        mem_ren   = ~cpu_wen;
      end
      2'b01: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_wen   = ext_wen;
        mem_ren   = ~ext_wen;
      end
      default: ;
    endcase
  end

  // Starvation counter and priority FSM; both freeze while disabled
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    state_d    = state_q;
    if (enable) begin
      if (ext_req && !ext_gnt) begin
        wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
      end else begin
        wait_cnt_d = 4'd0;
      end
      unique case (state_q)
        StNorm: begin
          if (wait_cnt_d >= MaxWait) begin
            state_d = StForce;
          end
        end
        StForce: begin
          if (ext_gnt || !ext_req) begin
            state_d = StNorm;
          end
        end
        default: state_d = StNorm;
      endcase
    end
  end

  // Read return path: the owner of last cycle's read sees SRAM data, the other holds its value
  always_comb begin
    owner_d = OwnNone;
    if (mem_ren) begin
      owner_d = cpu_gnt ? OwnCpu : OwnExt;
    end
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    if (owner_q == OwnCpu) begin
      cpu_rdata_d = mem_rdata;
    end
    if (owner_q == OwnExt) begin
      ext_rdata_d = mem_rdata;
    end
  end

  assign cpu_rvalid   = (owner_q == OwnCpu);
  assign ext_rvalid   = (owner_q == OwnExt);
  assign cpu_rdata    = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata    = ext_rvalid ? mem_rdata : ext_rdata_q;
  assign ext_wait_cnt = wait_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StNorm;
      owner_q     <= OwnNone;
      wait_cnt_q  <= 4'd0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!arst_n) !(cpu_gnt && ext_gnt));
  a_no_gnt_disabled: assert property (@(posedge clk) disable iff (!arst_n)
    !enable |-> !(cpu_gnt || ext_gnt || mem_wen || mem_ren));
  a_rw_excl: assert property (@(posedge clk) disable iff (!arst_n) !(mem_wen && mem_ren));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: u_dut (MAX_WAIT=4) with a behavioural SRAM, and
// u_sat (MAX_WAIT=15) for the starvation saturation case.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic clk, arst_n, enable;
  logic cpu_req, cpu_wen, ext_req, ext_wen;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata;

  logic cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_wen, mem_ren;
  logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0] ext_wait_cnt;

  logic s_cpu_gnt, s_cpu_stall, s_cpu_rvalid, s_ext_gnt, s_ext_rvalid, s_mem_wen, s_mem_ren;
  logic [DW-1:0] s_cpu_rdata, s_ext_rdata, s_mem_wdata;
  logic [DW-1:0] s_mem_rdata;
  logic [AW-1:0] s_mem_addr;
  logic [3:0] s_ext_wait_cnt;

  logic [DW-1:0] sram [256];
  logic [DW-1:0] sram_rd_q;

  int n_total = 0;
  int n_bad = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(4)) u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ext_wait_cnt(ext_wait_cnt)
  );

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(15)) u_sat (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(s_cpu_gnt), .cpu_stall(s_cpu_stall), .cpu_rvalid(s_cpu_rvalid),
    .cpu_rdata(s_cpu_rdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(s_ext_gnt), .ext_rvalid(s_ext_rvalid), .ext_rdata(s_ext_rdata),
    .mem_addr(s_mem_addr), .mem_wen(s_mem_wen), .mem_ren(s_mem_ren), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .ext_wait_cnt(s_ext_wait_cnt)
  );

  assign s_mem_rdata = '0;
  assign mem_rdata   = sram_rd_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
    if (mem_ren) sram_rd_q <= sram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic wen, input logic [7:0] a, input logic [31:0] d);
    cpu_req = req; cpu_wen = wen; cpu_addr = {24'd0, a}; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic wen, input logic [7:0] a, input logic [31:0] d);
    ext_req = req; ext_wen = wen; ext_addr = {24'd0, a}; ext_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'd0;
    sram[8'h10] = 32'hDEADBEEF;
    sram[8'h11] = 32'h11111111;
    sram_rd_q = 32'd0;
    arst_n = 1'b0;
    enable = 1'b0;
    set_cpu(0, 0, 8'h00, 32'd0);
    set_ext(0, 0, 8'h00, 32'd0);
    #1;
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_ext_rvalid", ext_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_wait_cnt", ext_wait_cnt, 0);

    // CPU-only read in the first cycle after release
    @(negedge clk);
    arst_n = 1'b1;
    enable = 1'b1;
    set_cpu(1, 0, 8'h10, 32'd0);
    #1;
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_mem_ren", mem_ren, 1);
    check("rd_mem_addr", mem_addr, 32'h10);
    check("rd_cpu_stall", cpu_stall, 0);
    cycle();
    set_cpu(0, 0, 8'h00, 32'd0);
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_ext_rvalid", ext_rvalid, 0);
    cycle();
    check("idle_cpu_rvalid", cpu_rvalid, 0);
    check("idle_cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    check("idle_mem_addr", mem_addr, 0);

    // Sustained contention: CPU x4, EXT x1, repeating
    set_cpu(1, 0, 8'h10, 32'd0);
    set_ext(1, 0, 8'h11, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      #1;
      check($sformatf("ct_cpu_gnt_%0d", k), cpu_gnt, ((k % 5) != 0));
      check($sformatf("ct_ext_gnt_%0d", k), ext_gnt, ((k % 5) == 0));
      check($sformatf("ct_stall_%0d", k), cpu_stall, ((k % 5) == 0));
      check($sformatf("ct_cnt_%0d", k), ext_wait_cnt, (k - 1) % 5);
      if (k == 6) begin
        check("ct_ext_rvalid", ext_rvalid, 1);
        check("ct_ext_rdata", ext_rdata, 32'h11111111);
        check("ct_cpu_rvalid_b2b", cpu_rvalid, 0);
      end
      if (k == 7) begin
        check("ct_cpu_rvalid", cpu_rvalid, 1);
        check("ct_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("ct_ext_rvalid_b2b", ext_rvalid, 0);
      end
      cycle();
    end
    set_cpu(0, 0, 8'h00, 32'd0);
    set_ext(0, 0, 8'h00, 32'd0);
    cycle();

    // CPU write then EXT read of the same word
    set_cpu(1, 1, 8'h20, 32'h55);
    #1;
    check("wr_mem_wen", mem_wen, 1);
    check("wr_mem_ren", mem_ren, 0);
    check("wr_mem_addr", mem_addr, 32'h20);
    check("wr_mem_wdata", mem_wdata, 32'h55);
    cycle();
    set_cpu(0, 0, 8'h00, 32'd0);
    set_ext(1, 0, 8'h20, 32'd0);
    #1;
    check("wr_ext_gnt", ext_gnt, 1);
    check("wr_no_cpu_rvalid", cpu_rvalid, 0);
    cycle();
    set_ext(0, 0, 8'h00, 32'd0);
    check("wr_ext_rvalid", ext_rvalid, 1);
    check("wr_ext_rdata", ext_rdata, 32'h55);
    cycle();
    check("wr_ext_rdata_hold", ext_rdata, 32'h55);

    // Enable low freezes counter and blocks grants
    set_cpu(1, 0, 8'h10, 32'd0);
    set_ext(1, 0, 8'h11, 32'd0);
    cycle();
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) check("en_rvalid_inflight", cpu_rvalid, 1);
      if (i == 1) check("en_rvalid_done", cpu_rvalid, 0);
      check($sformatf("en_gnt_%0d", i), {cpu_gnt, ext_gnt}, 2'b00);
      check($sformatf("en_mem_%0d", i), {mem_wen, mem_ren}, 2'b00);
      check($sformatf("en_cnt_%0d", i), ext_wait_cnt, 2);
      cycle();
    end
    check("en_stall", cpu_stall, 1);
    enable = 1'b1;
    #1;
    check("en_back_cpu_gnt", cpu_gnt, 1);
    check("en_back_cnt", ext_wait_cnt, 2);
    cycle();
    set_cpu(0, 0, 8'h00, 32'd0);
    set_ext(0, 0, 8'h00, 32'd0);
    cycle();

    // Reset right after an EXT read grant discards the return
    set_cpu(1, 0, 8'h10, 32'd0);
    set_ext(1, 0, 8'h11, 32'd0);
    for (int k = 0; k < 4; k++) cycle();
    #1;
    check("rs_ext_gnt", ext_gnt, 1);
    check("rs_cnt_pre", ext_wait_cnt, 4);
    cycle();
    arst_n = 1'b0;
    #1;
    check("rs_ext_rvalid", ext_rvalid, 0);
    check("rs_ext_rdata", ext_rdata, 0);
    check("rs_cnt", ext_wait_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("rs_cpu_first", cpu_gnt, 1);
    check("rs_ext_nogrant", ext_gnt, 0);
    cycle();
    check("rs_ext_rvalid_after", ext_rvalid, 0);
    check("rs_cpu_rvalid_after", cpu_rvalid, 1);
    check("rs_cnt_after", ext_wait_cnt, 1);
    set_cpu(0, 0, 8'h00, 32'd0);
    set_ext(0, 0, 8'h00, 32'd0);
    cycle();

    // MAX_WAIT=15: counter climbs to 15, EXT granted on the 16th cycle
    set_cpu(1, 0, 8'h10, 32'd0);
    set_ext(1, 0, 8'h11, 32'd0);
    for (int k = 1; k <= 17; k++) begin
      #1;
      check($sformatf("sat_cnt_%0d", k), s_ext_wait_cnt, (k <= 16) ? k - 1 : 0);
      check($sformatf("sat_ext_gnt_%0d", k), s_ext_gnt, (k == 16));
      check($sformatf("sat_cpu_gnt_%0d", k), s_cpu_gnt, (k != 16));
      cycle();
    end
    set_cpu(0, 0, 8'h00, 32'd0);
    set_ext(0, 0, 8'h00, 32'd0);
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width passed to data memory port.
REQ-003 SHALL have parameter MAX_WAIT, default 4, consecutive denied external cycles before forced external grant (range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  arbitration enable; low = no grants, no memory access.
REQ-007 SHALL have ports cpu_req/cpu_wen  input  1 each  pipeline MEM-stage access request / write (0 = read).
REQ-008 SHALL have ports cpu_addr  input  ADDR_W and cpu_wdata  input  DATA_W  pipeline access address and write data.
REQ-009 SHALL have ports cpu_gnt, cpu_stall, cpu_rvalid  output  1 each, and cpu_rdata  output  DATA_W.
REQ-010 SHALL have ports ext_req/ext_wen  input  1 each, ext_addr  input  ADDR_W, ext_wdata  input  DATA_W  host access.
REQ-011 SHALL have ports ext_gnt, ext_rvalid  output  1 each, and ext_rdata  output  DATA_W.
REQ-012 SHALL have ports mem_addr  output  ADDR_W, mem_wen/mem_ren  output  1 each, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W  single-port synchronous SRAM, read data one cycle after mem_ren.
REQ-013 SHALL have port ext_wait_cnt  output  4  current starvation count (debug).

Function
REQ-014 SHALL grant at most one requester per cycle; grant decision combinational from req, enable and registered state; the access is issued in the grant cycle.
REQ-015 SHALL use FSM states NORM (CPU priority) and FORCE (external priority).
REQ-016 In NORM, cpu_req -> cpu_gnt; else ext_req -> ext_gnt.
REQ-017 In FORCE, ext_req -> ext_gnt; cpu_req without ext_req -> cpu_gnt.
REQ-018 ext_wait_cnt SHALL increment (saturating at 15) each enabled cycle with ext_req high and ext_gnt low; SHALL clear on ext_gnt or ext_req low.
REQ-019 NORM -> FORCE when the next ext_wait_cnt value reaches MAX_WAIT; FORCE -> NORM on the cycle after any ext_gnt, or when ext_req drops.
REQ-020 Granted requester's addr/wdata SHALL drive mem_addr/mem_wdata; mem_wen = granted & wen; mem_ren = granted & ~wen; with no grant mem_wen=mem_ren=0, mem_addr/mem_wdata = 0.
REQ-021 SHALL register read owner (CPU/EXT/none) at each read grant; following cycle the owner's rvalid=1 and its rdata = mem_rdata; the non-owner's rvalid=0 and its rdata holds last value.
REQ-022 Back-to-back reads (either owner) SHALL be supported every cycle with no bubble.
REQ-023 cpu_stall = cpu_req & ~cpu_gnt (combinational), for holding the pipeline.
REQ-024 Requesters SHALL hold req/addr/wdata/wen stable until granted; the arbiter need not tolerate changes before grant.
REQ-025 enable low: no gnt, no mem access, FSM and ext_wait_cnt hold; a read issued before enable fell still returns rvalid next cycle.
REQ-026 Writes SHALL produce no rvalid.

Reset
REQ-027 On arst_n low: FSM = NORM, ext_wait_cnt = 0, read owner = none, cpu_rvalid = ext_rvalid = 0, cpu_rdata = ext_rdata = 0, immediately and independent of clk.
REQ-028 Reset asserted while a read is outstanding SHALL discard it; no rvalid after release.
REQ-029 First grant possible in the first rising edge cycle with arst_n high.

Verification
REQ-030 CPU-only read: cpu_req=1, wen=0, addr=0x10, SRAM[0x10]=0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF next cycle, ext_rvalid=0.
REQ-031 Contention, MAX_WAIT=4: cpu_req and ext_req held high continuously -> CPU granted 4 cycles, ext_wait_cnt 1,2,3,4, ext_gnt on 5th cycle (cpu_stall=1 there), then CPU again; pattern repeats.
REQ-032 Interleaved: CPU write 0x55 to 0x20 in cycle N, ext read 0x20 in cycle N+1 -> ext_rvalid at N+2 with ext_rdata=0x55.
REQ-033 enable=0 with both req high for 10 cycles -> no gnt, mem_wen=mem_ren=0, ext_wait_cnt unchanged.
REQ-034 arst_n pulled low the cycle after an ext read grant -> ext_rvalid stays 0, ext_wait_cnt=0, state NORM; after release cpu_req granted first cycle.
REQ-035 Saturation: MAX_WAIT=15, ext_req held, cpu_req held 20 cycles -> ext_wait_cnt stops at 15 and ext_gnt issued the 16th cycle.
